// File: rtl/rv_mc_core.sv
// rv_mc_core: multicycle RV32I-subset core sharing one req/ready memory port for fetch and data.
// Define RV_MC_RETIRE_CNT_EN to add the instret retired-instruction counter output.
module rv_mc_core #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        NREG     = 32,
  parameter logic [ADDR_W-1:0]  PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req,
  input  logic              ready,
  input  logic [31:0]       rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output logic              write,
  output logic              done,
  output logic              err
`ifdef RV_MC_RETIRE_CNT_EN
  , output logic [31:0]     instret
`endif
);

  localparam int unsigned RW = $clog2(NREG);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [31:0]       ir, a, b, imm, res;
  logic              wr_rd, taken;
  logic [31:0]       rf [NREG];

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [RW-1:0]     rd_idx, rs1_idx, rs2_idx;
  logic [31:0]       imm_i, imm_s, imm_b, imm_j, imm_sel;
  logic [31:0]       sum, alu;
  logic              legal, wr_en, br;
  logic [ADDR_W-1:0] pc_plus4, tsum, next_pc;

  assign opcode  = ir[6:0];
  assign f3      = ir[14:12];
  assign f7      = ir[31:25];
  assign rd_idx  = ir[7 +: RW];
  assign rs1_idx = ir[15 +: RW];
  assign rs2_idx = ir[20 +: RW];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    imm_sel = imm_i;
    case (opcode)
      OP_STORE:  imm_sel = imm_s;
      OP_BRANCH: imm_sel = imm_b;
      OP_JAL:    imm_sel = imm_j;
      default:   imm_sel = imm_i;
    endcase
  end

  assign sum      = a + imm;
  assign pc_plus4 = pc + ADDR_W'(4);
  // Branch and JAL both add the registered immediate to the PC; low bits cleared to stay word aligned.
  assign tsum     = pc + imm[ADDR_W-1:0];
  assign next_pc  = taken ? target : pc_plus4;

  always_comb begin
    alu   = '0;
    legal = 1'b0;
    wr_en = 1'b0;
    br    = 1'b0;
    case (opcode)
      OP_R: begin
        legal = 1'b1;
        wr_en = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: alu = a + b;
          {7'h20, 3'b000}: alu = a - b;
          {7'h00, 3'b111}: alu = a & b;
          {7'h00, 3'b110}: alu = a | b;
          {7'h00, 3'b100}: alu = a ^ b;
          {7'h00, 3'b010}: alu = {31'b0, $signed(a) < $signed(b)};
          default: begin
            legal = 1'b0;
            wr_en = 1'b0;
          end
        endcase
      end
      OP_IMM: if (f3 == 3'b000) begin
        legal = 1'b1;
        wr_en = 1'b1;
        alu   = sum;
      end
      OP_LOAD: if (f3 == 3'b010) begin
        legal = 1'b1;
        wr_en = 1'b1;
      end
      OP_STORE:  legal = (f3 == 3'b010);
      OP_BRANCH: begin
        if (f3 == 3'b000) begin
          legal = 1'b1;
          br    = (a == b);
        end else if (f3 == 3'b001) begin
          legal = 1'b1;
          br    = (a != b);
        end
      end
      OP_JAL: begin
        legal = 1'b1;
        wr_en = 1'b1;
        br    = 1'b1;
        alu   = 32'(pc_plus4);
      end
      OP_SYSTEM: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= PC_RESET;
      req    <= 1'b0;
      write  <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      imm    <= '0;
      res    <= '0;
      wr_rd  <= 1'b0;
      taken  <= 1'b0;
      target <= '0;
`ifdef RV_MC_RETIRE_CNT_EN
      instret <= '0;
`endif
    end else begin
      case (state)
        FETCH: begin
          // Only the first fetch after reset enters with req low; WB pre-arms the others.
          if (!req) begin
            req  <= 1'b1;
            addr <= pc;
          end else if (ready) begin
            req   <= 1'b0;
            ir    <= rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          a     <= (rs1_idx == '0) ? '0 : rf[rs1_idx];
          b     <= (rs2_idx == '0) ? '0 : rf[rs2_idx];
          imm   <= imm_sel;
          state <= EXEC;
        end
        EXEC: begin
          res    <= alu;
          wr_rd  <= wr_en && (rd_idx != '0);
          taken  <= br;
          target <= {tsum[ADDR_W-1:2], 2'b00};
          if (!legal) begin
            err   <= 1'b1;
            state <= HALT;
          end else if (opcode == OP_SYSTEM) begin
            done  <= 1'b1;
            state <= HALT;
          end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
            req   <= 1'b1;
            write <= (opcode == OP_STORE);
            addr  <= {sum[ADDR_W-1:2], 2'b00};
            if (opcode == OP_STORE) wdata <= b;
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (ready) begin
            req   <= 1'b0;
            write <= 1'b0;
            if (!write) res <= rdata;
            state <= WB;
          end
        end
        WB: begin
          pc    <= next_pc;
          req   <= 1'b1;
          addr  <= next_pc;
          state <= FETCH;
`ifdef RV_MC_RETIRE_CNT_EN
          instret <= instret + 32'd1;
`endif
        end
        HALT: begin
          req   <= 1'b0;
          write <= 1'b0;
        end
        default: state <= HALT;
      endcase
    end
  end

  // Register file deliberately has no reset; x0 is handled at the read side.
  always_ff @(posedge clk) begin
    if (!rst && state == WB && wr_rd) rf[rd_idx] <= res;
  end

endmodule

// File: tb/tb_rv_mc_core.sv
// tb_rv_mc_core: directed programs against a word memory model with read/store scoreboards.
// Builds with or without RV_MC_RETIRE_CNT_EN; instret checks follow the macro.
module tb_rv_mc_core;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] NOWHERE  = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req, ready, write, done, err;
  logic [31:0] rdata, addr, wdata;
`ifdef RV_MC_RETIRE_CNT_EN
  logic [31:0] instret;
`endif

  logic [31:0] mem [256];
  logic [31:0] exp_rd [$];
  logic [63:0] exp_st [$];
  int unsigned fstart [logic [31:0]];
  int unsigned n_chk = 0, n_pass = 0, n_fail = 0;
  int unsigned cyc = 0, wcnt = 0;
  logic [31:0] stall_a0 = NOWHERE, stall_a1 = NOWHERE;
  logic        block_wr = 1'b0;
  logic        prev_req = 1'b0, prev_ready = 1'b1;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  rv_mc_core #(.ADDR_W(32), .NREG(32), .PC_RESET(32'h40)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .rdata(rdata),
    .addr(addr), .wdata(wdata), .write(write), .done(done), .err(err)
`ifdef RV_MC_RETIRE_CNT_EN
    , .instret(instret)
`endif
  );

  assign rdata = mem[addr[9:2]];
  assign ready = !(req && ((!write && (addr == stall_a0 || addr == stall_a1) && wcnt < 3)
                          || (write && block_wr)));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req && !ready) wcnt <= wcnt + 1;
    else               wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic miss(input string tag, input logic [31:0] obs);
    n_chk++;
    n_fail++;
    $error("FAIL %s: observed %h expected none", tag, obs);
  endtask

  // Memory-side monitor: scoreboards every accepted transfer and the hold rule while stalled.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (prev_req && !prev_ready) begin
        check("req_hold", {31'b0, req}, 32'd1);
        check("addr_hold", addr, prev_addr);
      end
      if (req && !write && !prev_req) fstart[addr] = cyc;
      if (req && ready) begin
        if (write) begin
          if (exp_st.size() == 0) miss("unexpected_store", addr);
          else begin
            e = exp_st.pop_front();
            check("st_addr", addr, e[63:32]);
            check("st_data", wdata, e[31:0]);
          end
          mem[addr[9:2]] = wdata;
        end else begin
          if (exp_rd.size() == 0) miss("unexpected_read", addr);
          else check("rd_addr", addr, exp_rd.pop_front());
        end
      end
    end
    prev_req   = req;
    prev_ready = ready;
    prev_addr  = addr;
  end

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, (op == OP_LOAD) ? 3'b010 : 3'b000, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask
  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    exp_st.push_back({a, d});
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic wait_halt(input string tag, input int unsigned lim);
    int unsigned k = 0;
    while (!(done || err) && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'b0, done | err}, 32'd1);
  endtask
  task automatic check_parked(input string tag, input int unsigned n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, {31'b0, req}, 32'd0);
    end
  endtask

  initial begin
    // ---------------- Program A: ALU, stalled LW, branches, JAL, x0, EBREAK
    clear_mem();
    put(32'h40, enc_i(OP_IMM, 1, 0, 32'd5));
    put(32'h44, enc_i(OP_IMM, 2, 0, 32'd7));
    put(32'h48, enc_r(7'h00, 3'b000, 3, 1, 2));      // ADD
    put(32'h4C, enc_r(7'h20, 3'b000, 4, 1, 2));      // SUB
    put(32'h50, enc_s(3, 0, 32'h0));
    put(32'h54, enc_s(4, 0, 32'h4));
    put(32'h58, enc_i(OP_LOAD, 5, 0, 32'h4));
    put(32'h5C, enc_s(5, 0, 32'h100));
    put(32'h60, enc_r(7'h00, 3'b111, 6, 1, 2));      // AND
    put(32'h64, enc_r(7'h00, 3'b110, 7, 1, 2));      // OR
    put(32'h68, enc_r(7'h00, 3'b100, 8, 1, 2));      // XOR
    put(32'h6C, enc_r(7'h00, 3'b010, 9, 4, 1));      // SLT -2<5
    put(32'h70, enc_r(7'h00, 3'b010, 10, 1, 4));     // SLT 5<-2
    put(32'h74, enc_s(6, 0, 32'h104));
    put(32'h78, enc_s(7, 0, 32'h108));
    put(32'h7C, enc_s(8, 0, 32'h10C));
    put(32'h80, enc_s(9, 0, 32'h110));
    put(32'h84, enc_s(10, 0, 32'h114));
    put(32'h88, enc_i(OP_IMM, 0, 0, 32'd9));
    put(32'h8C, enc_s(0, 0, 32'h118));
    put(32'h90, enc_b(3'b001, 0, 0, 32'd8));         // BNE not taken
    put(32'h94, enc_i(OP_IMM, 12, 0, 32'd0));
    put(32'h98, enc_j(0, 32'hFFFF_FF78));            // -> 0x10
    put(32'h10, enc_b(3'b000, 0, 0, 32'd10));        // BEQ +10 -> 0x18
    put(32'h14, EBREAK);
    put(32'h18, enc_b(3'b001, 12, 0, 32'h20));       // exits on second pass
    put(32'h1C, enc_i(OP_IMM, 12, 0, 32'd1));
    put(32'h20, enc_j(1, 32'hFFFF_FFF0));            // JAL x1,-16
    put(32'h38, enc_s(1, 0, 32'h11C));
    put(32'h3C, EBREAK);
    stall_a0 = 32'h58;
    stall_a1 = 32'h4;
    for (int a = 32'h40; a <= 32'h98; a += 4) begin
      exp_rd.push_back(32'(a));
      if (a == 32'h58) exp_rd.push_back(32'h4);
    end
    foreach (exp_rd[i]) if (i < 0) exp_rd.delete();
    exp_rd.push_back(32'h10); exp_rd.push_back(32'h18); exp_rd.push_back(32'h1C);
    exp_rd.push_back(32'h20); exp_rd.push_back(32'h10); exp_rd.push_back(32'h18);
    exp_rd.push_back(32'h38); exp_rd.push_back(32'h3C);
    push_st(32'h0, 32'd12);
    push_st(32'h4, 32'hFFFF_FFFE);
    push_st(32'h100, 32'hFFFF_FFFE);
    push_st(32'h104, 32'd5);
    push_st(32'h108, 32'd7);
    push_st(32'h10C, 32'd2);
    push_st(32'h110, 32'd1);
    push_st(32'h114, 32'd0);
    push_st(32'h118, 32'd0);
    push_st(32'h11C, 32'h24);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_write", {31'b0, write}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
`ifdef RV_MC_RETIRE_CNT_EN
    check("rst_instret", instret, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    begin
      int unsigned k = 0;
      while (!req && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
    check("first_req", {31'b0, req}, 32'd1);
    check("first_addr", addr, 32'h40);
    check("first_write", {31'b0, write}, 32'd0);
    wait_halt("a_halt_timeout", 2000);
    check("a_done", {31'b0, done}, 32'd1);
    check("a_err", {31'b0, err}, 32'd0);
    check("a_rd_left", exp_rd.size(), 32'd0);
    check("a_st_left", exp_st.size(), 32'd0);
    check("addi_cycles", 32'(fstart[32'h48] - fstart[32'h44]), 32'd4);
    check("add_cycles", 32'(fstart[32'h4C] - fstart[32'h48]), 32'd4);
    check("sw_cycles", 32'(fstart[32'h54] - fstart[32'h50]), 32'd5);
    check("lw_stall_cycles", 32'(fstart[32'h5C] - fstart[32'h58]), 32'd11);
    check_parked("a_halt_req", 20);
    check("a_done_sticky", {31'b0, done}, 32'd1);

    // ---------------- Program B: illegal opcode
    clear_mem();
    put(32'h40, 32'h0000_007F);
    stall_a0 = NOWHERE;
    stall_a1 = NOWHERE;
    exp_rd.push_back(32'h40);
    do_reset();
    wait_halt("b_halt_timeout", 100);
    check("b_err", {31'b0, err}, 32'd1);
    check("b_done", {31'b0, done}, 32'd0);
    check("b_rd_left", exp_rd.size(), 32'd0);
    check_parked("b_halt_req", 10);
    check("b_err_sticky", {31'b0, err}, 32'd1);

    // ---------------- Program C: reset while a store is stalled in MEM
    clear_mem();
    put(32'h40, enc_i(OP_IMM, 1, 0, 32'd3));
    put(32'h44, enc_s(1, 0, 32'h120));
    put(32'h48, enc_i(OP_IMM, 2, 0, 32'd1));
    put(32'h4C, enc_i(OP_IMM, 2, 2, 32'd1));
    put(32'h50, enc_i(OP_IMM, 2, 2, 32'd1));
    put(32'h54, enc_i(OP_IMM, 2, 2, 32'd1));
    put(32'h58, EBREAK);
    block_wr = 1'b1;
    exp_rd.push_back(32'h40);
    exp_rd.push_back(32'h44);
    do_reset();
    begin
      int unsigned k = 0;
      while (!(req && write) && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    check("c_store_req", {31'b0, req & write}, 32'd1);
    check("c_store_addr", addr, 32'h120);
    check("c_store_data", wdata, 32'd3);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("c_rst_req_drop", {31'b0, req}, 32'd0);
    check("c_rst_write_drop", {31'b0, write}, 32'd0);
`ifdef RV_MC_RETIRE_CNT_EN
    check("c_rst_instret", instret, 32'd0);
`endif
    for (int a = 32'h40; a <= 32'h58; a += 4) exp_rd.push_back(32'(a));
    push_st(32'h120, 32'd3);
    block_wr = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    wait_halt("c_halt_timeout", 200);
    check("c_done", {31'b0, done}, 32'd1);
    check("c_err", {31'b0, err}, 32'd0);
    check("c_rd_left", exp_rd.size(), 32'd0);
    check("c_st_left", exp_st.size(), 32'd0);
`ifdef RV_MC_RETIRE_CNT_EN
    check("c_instret", instret, 32'd6);
`endif
    check_parked("c_halt_req", 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
